// File: rtl/jtcontra_inputs.sv
// Cabinet input conditioner: 2-flop sync, per-bit debounce, SOCD cleaning and frame-counted coin pulses, all outputs registered.
// Optional b1 autofire is compiled in with JTCONTRA_AUTOFIRE_EN; no backpressure, inputs are sampled every cycle.
module jtcontra_inputs #(
  parameter int TICKW       = 10,
  parameter int DEBW        = 4,
  parameter int COIN_FRAMES = 3,
  parameter int AF_FRAMES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LVBL,
  input  logic [1:0] start_button,
  input  logic [1:0] coin_input,
  input  logic [5:0] joystick1,
  input  logic [5:0] joystick2,
  input  logic       af_en,
  output logic [1:0] start_o,
  output logic [1:0] coin_o,
  output logic [5:0] joy1_o,
  output logic [5:0] joy2_o
);

  localparam int              FCW     = $clog2(COIN_FRAMES + 1);
  localparam int              AFW     = $clog2(AF_FRAMES + 1);
  localparam logic [DEBW-1:0] DC_LAST = DEBW'((1 << DEBW) - 2);
  localparam logic [FCW-1:0]  FC_LAST = FCW'(COIN_FRAMES - 1);
  localparam logic [AFW-1:0]  AF_LAST = AFW'(AF_FRAMES - 1);

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT} coin_st_t;

  // bit map: [15:14] start, [13:12] coin, [11:6] joystick2, [5:0] joystick1
  logic [15:0]      raw, sync1, sync2, db;
  logic [DEBW-1:0]  dc [16];
  logic [TICKW-1:0] tick_cnt;
  logic             tick;
  logic             lvbl_q, frame;
  logic [1:0]       b1;
  logic [5:0]       j1c, j2c;

  assign raw   = {start_button, coin_input, joystick2, joystick1};
  assign tick  = &tick_cnt;
  assign frame = lvbl_q & ~LVBL;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '1;
      sync2    <= '1;
      tick_cnt <= '0;
      lvbl_q   <= 1'b1;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      tick_cnt <= tick_cnt + 1'b1;
      lvbl_q   <= LVBL;
    end
  end

  // Acceptance happens on the tick that would bring dc to all-ones, so dc never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      db <= '1;
      for (int i = 0; i < 16; i++) dc[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (sync2[i] == db[i]) begin
          dc[i] <= '0;
        end else if (tick) begin
          if (dc[i] == DC_LAST) begin
            db[i] <= sync2[i];
            dc[i] <= '0;
          end else begin
            dc[i] <= dc[i] + 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [5:0] socd(input logic [5:0] j);
    socd = j;
    if (!j[3] && !j[2]) socd[3:2] = 2'b11;
    if (!j[1] && !j[0]) socd[1:0] = 2'b11;
  endfunction

  assign j1c = socd(db[5:0]);
  assign j2c = socd(db[11:6]);

  coin_st_t       cst [2];
  coin_st_t       cst_nx [2];
  logic [FCW-1:0] fc [2];
  logic [FCW-1:0] fc_nx [2];
  logic [1:0]     coin_nx, db_coin_q, coin_fall;

  assign coin_fall = db_coin_q & ~db[13:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      db_coin_q <= 2'b11;
      coin_o    <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        cst[i] <= C_IDLE;
        fc[i]  <= '0;
      end
    end else begin
      db_coin_q <= db[13:12];
      coin_o    <= coin_nx;
      for (int i = 0; i < 2; i++) begin
        cst[i] <= cst_nx[i];
        fc[i]  <= fc_nx[i];
      end
    end
  end

  // Entry into PULSE wins over a coincident frame strobe: fc starts at 0 without counting it.
  always_comb begin
    coin_nx = coin_o;
    for (int i = 0; i < 2; i++) begin
      cst_nx[i] = cst[i];
      fc_nx[i]  = fc[i];
      case (cst[i])
        C_IDLE: if (coin_fall[i]) begin
          cst_nx[i]  = C_PULSE;
          fc_nx[i]   = '0;
          coin_nx[i] = 1'b0;
        end
        C_PULSE: if (frame) begin
          if (fc[i] == FC_LAST) begin
            cst_nx[i]  = C_WAIT;
            coin_nx[i] = 1'b1;
          end else begin
            fc_nx[i] = fc[i] + 1'b1;
          end
        end
        C_WAIT: if (db[12+i]) cst_nx[i] = C_IDLE;
        default: cst_nx[i] = C_IDLE;
      endcase
    end
  end

`ifdef JTCONTRA_AUTOFIRE_EN
  logic [1:0]     af_act, af_lvl;
  logic [AFW-1:0] af_cnt [2];

  assign af_act = {2{af_en}} & ~{db[10], db[4]};

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst || !af_act[p]) begin
        af_lvl[p] <= 1'b0;
        af_cnt[p] <= '0;
      end else if (frame) begin
        if (af_cnt[p] == AF_LAST) begin
          af_cnt[p] <= '0;
          af_lvl[p] <= ~af_lvl[p];
        end else begin
          af_cnt[p] <= af_cnt[p] + 1'b1;
        end
      end
    end
  end

  assign b1 = {af_act[1] ? af_lvl[1] : db[10], af_act[0] ? af_lvl[0] : db[4]};
`else
  logic unused_af;
  assign unused_af = ^{af_en, AF_LAST};
  assign b1 = {db[10], db[4]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      start_o <= 2'b11;
      joy1_o  <= '1;
      joy2_o  <= '1;
    end else begin
      start_o <= db[15:14];
      joy1_o  <= {j1c[5], b1[0], j1c[3:0]};
      joy2_o  <= {j2c[5], b1[1], j2c[3:0]};
    end
  end

endmodule

// File: tb/tb_jtcontra_inputs.sv
// Bench for jtcontra_inputs with TICKW=2, DEBW=2: three ticks of 4 cycles accept an input.
module tb_jtcontra_inputs;

  logic       clk = 1'b0;
  logic       rst, LVBL, af_en;
  logic [1:0] start_button, coin_input;
  logic [5:0] joystick1, joystick2;
  logic [1:0] start_o, coin_o;
  logic [5:0] joy1_o, joy2_o;

  always #5 clk = ~clk;

  jtcontra_inputs #(.TICKW(2), .DEBW(2), .COIN_FRAMES(3), .AF_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .LVBL(LVBL),
    .start_button(start_button), .coin_input(coin_input),
    .joystick1(joystick1), .joystick2(joystick2), .af_en(af_en),
    .start_o(start_o), .coin_o(coin_o), .joy1_o(joy1_o), .joy2_o(joy2_o)
  );

  int tests = 0, fails = 0;

  string       name_q[$];
  logic [15:0] val_q[$];

  task automatic push_exp(input string n, input logic [15:0] v);
    name_q.push_back(n);
    val_q.push_back(v);
  endtask

  task automatic check_next(input logic [15:0] act);
    string       n;
    logic [15:0] v;
    tests++;
    if (val_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      n = name_q.pop_front();
      v = val_q.pop_front();
      if (act !== v) begin
        fails++;
        $display("FAIL %s actual=%h required=%h", n, act, v);
      end
    end
  endtask

  task automatic check_range(input string n, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d..%0d", n, act, lo, hi);
    end
  endtask

  // LVBL modes: 0 hold high, 1 run frames (24-cycle period), 2 hold low
  int   cyc = 0;
  int   lv_mode = 2;
  int   frames_low = 0, coin0_falls = 0;
  logic lvbl_prev = 1'b1, coin0_prev = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (lv_mode)
      1:       LVBL = ((cyc % 24) < 16);
      2:       LVBL = 1'b0;
      default: LVBL = 1'b1;
    endcase
    if (lvbl_prev && !LVBL && !coin_o[0]) frames_low++;
    if (coin0_prev && !coin_o[0]) coin0_falls++;
    lvbl_prev  = LVBL;
    coin0_prev = coin_o[0];
  endtask

  typedef struct {
    logic [1:0] st;
    logic [5:0] j1, j2;
    logic [1:0] est;
    logic [5:0] ej1, ej2;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;

    vecs[0] = '{2'b11, 6'b111111, 6'b111111, 2'b11, 6'b111111, 6'b111111};
    vecs[1] = '{2'b11, 6'b111111, 6'b111010, 2'b11, 6'b111111, 6'b111010};
    vecs[2] = '{2'b11, 6'b111111, 6'b110010, 2'b11, 6'b111111, 6'b111110};
    vecs[3] = '{2'b11, 6'b110101, 6'b111111, 2'b11, 6'b110101, 6'b111111};
    vecs[4] = '{2'b11, 6'b111100, 6'b111111, 2'b11, 6'b111111, 6'b111111};
    vecs[5] = '{2'b11, 6'b000000, 6'b111111, 2'b11, 6'b001111, 6'b111111};
    vecs[6] = '{2'b01, 6'b111111, 6'b111111, 2'b01, 6'b111111, 6'b111111};
    vecs[7] = '{2'b01, 6'b111111, 6'b101001, 2'b01, 6'b111111, 6'b101001};
    vecs[8] = '{2'b11, 6'b111111, 6'b110000, 2'b11, 6'b111111, 6'b111111};
    vecs[9] = '{2'b10, 6'b011011, 6'b111111, 2'b10, 6'b011011, 6'b111111};

    // reset with every input low
    rst = 1'b1; LVBL = 1'b0; af_en = 1'b0;
    start_button = '0; coin_input = '0; joystick1 = '0; joystick2 = '0;
    repeat (3) step();
    push_exp("rst_start", 16'h3);  check_next({14'b0, start_o});
    push_exp("rst_coin",  16'h3);  check_next({14'b0, coin_o});
    push_exp("rst_joy1",  16'h3F); check_next({10'b0, joy1_o});
    push_exp("rst_joy2",  16'h3F); check_next({10'b0, joy2_o});
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      push_exp("post_rst_coin", 16'h3);
      check_next({14'b0, coin_o});
    end
    start_button = '1; coin_input = '1; joystick1 = '1; joystick2 = '1; lv_mode = 0;
    push_exp("idle_coin", 16'h3);
    push_exp("idle_joy1", 16'h3F);
    repeat (25) step();
    check_next({14'b0, coin_o});
    check_next({10'b0, joy1_o});

    // table vectors: steady-state conditioning incl. SOCD
    for (int v = 0; v < 10; v++) begin
      start_button = vecs[v].st;
      joystick1    = vecs[v].j1;
      joystick2    = vecs[v].j2;
      push_exp($sformatf("vec%0d_start", v), {14'b0, vecs[v].est});
      push_exp($sformatf("vec%0d_joy1", v),  {10'b0, vecs[v].ej1});
      push_exp($sformatf("vec%0d_joy2", v),  {10'b0, vecs[v].ej2});
      repeat (20) step();
      check_next({14'b0, start_o});
      check_next({10'b0, joy1_o});
      check_next({10'b0, joy2_o});
    end

    // debounce latency on joystick1[4]
    start_button = '1; joystick1 = '1; joystick2 = '1;
    repeat (20) step();
    joystick1[4] = 1'b0;
    n = -1; found = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (!found && !joy1_o[4]) begin found = 1; n = k; end
    end
    check_range("debounce_latency", n, 11, 15);
    joystick1[4] = 1'b1;
    push_exp("debounce_release", 16'h3F);
    repeat (20) step();
    check_next({10'b0, joy1_o});

    // 5-cycle glitch must be rejected
    joystick1[4] = 1'b0;
    repeat (5) step();
    joystick1[4] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      push_exp("glitch_joy1", 16'h3F);
      check_next({10'b0, joy1_o});
    end

    // coin pulse over 10 frames of held input
    frames_low = 0; coin0_falls = 0; lv_mode = 1;
    coin_input[0] = 1'b0;
    push_exp("coin_pulses", 16'd1);
    push_exp("coin_frames_low", 16'd3);
    push_exp("coin_after", 16'h3);
    repeat (240) step();
    check_next(16'(coin0_falls));
    check_next(16'(frames_low));
    check_next({14'b0, coin_o});
    coin_input[0] = 1'b1;
    push_exp("coin_released", 16'h3);
    repeat (40) step();
    check_next({14'b0, coin_o});
    coin_input[0] = 1'b0;
    push_exp("coin_repress", 16'd2);
    repeat (60) step();
    check_next(16'(coin0_falls));
    coin_input[0] = 1'b1;
    push_exp("coin_done", 16'h3);
    repeat (150) step();
    check_next({14'b0, coin_o});

    // reset in the middle of a pulse on coin 1
    lv_mode = 0;
    coin_input[1] = 1'b0;
    for (int k = 0; k < 40 && coin_o[1]; k++) step();
    push_exp("mid_pulse_low", 16'h0);
    check_next({15'b0, coin_o[1]});
    rst = 1'b1;
    push_exp("mid_pulse_rst", 16'h3);
    step();
    check_next({14'b0, coin_o});
    rst = 1'b0;
    for (int k = 0; k < 40 && coin_o[1]; k++) step();
    push_exp("rearm_after_rst", 16'h0);
    check_next({15'b0, coin_o[1]});
    lv_mode = 1;
    coin_input[1] = 1'b1;
    push_exp("mid_pulse_done", 16'h3);
    repeat (150) step();
    check_next({14'b0, coin_o});

    if (val_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", val_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
